uart_stream_bridge: RTL and testbench

- Parametrised successor to the UART native-to-AXI-Stream adapter, sitting between a UART byte core (rx_dvalid/rx_data, tx_busy/tx_dvalid/tx_data) and the AXIS fabric/packet FIFOs.
- RX: frames bytes into packets by an internal, runtime-programmable idle timeout and a maximum-length limit, appends a configurable-width big-endian length trailer, and reports overruns in tuser.
- TX: serialises AXIS beats into single-cycle byte strobes.

---
 rtl/uart_stream_pkg.sv | 20 ++
 rtl/uart_stream_tx.sv | 49 ++++
 rtl/uart_stream_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_stream_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stream_pkg.sv
// Shared definitions for the UART <-> AXI-Stream bridge.
//   state_e : RX framing FSM states
//   CNT_W   : width of the saturating statistics counters
//   sat_inc : saturating increment helper for those counters
package uart_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TRAILER,
        ST_DROP
    } state_e;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/uart_stream_tx.sv
// TX half of the bridge: accepts one AXIS beat at a time and turns it into a
// single-cycle byte strobe for the UART transmitter.
// Ports:
//   clk, rstn        clock, async active-low reset
//   s_axis_tdata/
//   s_axis_tvalid/
//   s_axis_tready    AXIS sink (tready is registered)
//   tx_busy          UART transmitter busy
//   tx_dvalid/
//   tx_data          one-cycle byte strobe and byte to the UART
module uart_stream_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              tx_busy,
    output logic              tx_dvalid,
    output logic [DATA_W-1:0] tx_data
);

    logic              rdy_q;
    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic              hs;

    assign hs = s_axis_tvalid & rdy_q;

    // Ready drops for the handshake cycle and the strobe cycle, so a new byte
    // can never be offered to the UART before it has had a chance to go busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            rdy_q <= ~tx_busy & ~vld_q & ~hs;
            vld_q <= hs;
            if (hs) data_q <= s_axis_tdata;
        end
    end

    assign s_axis_tready = rdy_q;
    assign tx_dvalid     = vld_q;
    assign tx_data       = data_q;

endmodule

// File: rtl/uart_stream_bridge.sv
// UART byte core <-> AXI-Stream bridge.
// RX: frames received bytes into packets closed by a programmable idle
// timeout or a maximum payload length, appends a big-endian length trailer
// (payload + LEN_BYTES) and flags overruns in tuser on the final beat.
// TX: handled by uart_stream_tx.
// Ports:
//   clk, rstn                    clock, async active-low reset
//   cfg_idle_ticks               idle cycles that close a packet (0 acts as 1)
//   tdest                        registered onto m_axis_tdest
//   s_axis_*                     TX stream in (tlast/tkeep ignored)
//   m_axis_*                     RX stream out, single registered beat
//   tx_busy/tx_dvalid/tx_data    UART transmit side
//   rx_dvalid/rx_data            UART receive side
//   data_afull/pkt_afull         downstream FIFOs almost full -> drop packet
//   pkt_length/pkt_length_push   total length of last completed packet
//   drop_cnt/ovr_cnt/pkt_cnt     saturating statistics
// Build option: define UART_STREAM_BRIDGE_STATS_EN to instantiate the
// statistics counters; otherwise they read as 0.
module uart_stream_bridge
    import uart_stream_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LEN_BYTES = 4,
    parameter int LEN_W     = 32,
    parameter int MAX_PKT   = 1024,
    parameter int ID_W      = 5,
    parameter int DEST_W    = 5,
    parameter int TMO_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [TMO_W-1:0]  cfg_idle_ticks,
    input  logic [DEST_W-1:0] tdest,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tkeep,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tkeep,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [DEST_W-1:0] m_axis_tdest,
    output logic              m_axis_tuser,
    input  logic              tx_busy,
    output logic              tx_dvalid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_dvalid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              data_afull,
    input  logic              pkt_afull,
    output logic [LEN_W-1:0]  pkt_length,
    output logic              pkt_length_push,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  ovr_cnt,
    output logic [CNT_W-1:0]  pkt_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [ID_W-1:0]   tid_q, tid_d;
    logic [DEST_W-1:0] tdest_q;
    logic [LEN_W-1:0]  len_q, len_d, plen_q, plen_d;
    logic              push_q, push_d;
    logic [TMO_W-1:0]  idle_q, idle_d, thr;
    logic              ovr_q, ovr_d;
    logic [2:0]        tbeat_q, tbeat_d;
    logic              drop_inc, ovr_inc, pkt_inc;
    logic              hs, free_slot;
    logic [LEN_W-1:0]  tot;
    logic [7:0]        tbyte;
    logic              unused_tx;

    assign unused_tx = s_axis_tlast ^ s_axis_tkeep;

    assign thr       = (cfg_idle_ticks == '0) ? TMO_W'(1) : cfg_idle_ticks;
    assign hs        = tvalid_q & m_axis_tready;
    assign free_slot = ~tvalid_q | hs;
    assign tot       = len_q + LEN_W'(LEN_BYTES);
    // Trailer beat tbeat_q carries byte (LEN_BYTES-1-tbeat_q) of tot: MSB first.
    assign tbyte     = 8'(tot >> (8 * (LEN_BYTES - 1 - int'(tbeat_q))));

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q & ~hs;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        tid_d    = tid_q;
        len_d    = len_q;
        plen_d   = plen_q;
        push_d   = 1'b0;
        idle_d   = '0;
        ovr_d    = ovr_q;
        tbeat_d  = tbeat_q;
        drop_inc = 1'b0;
        ovr_inc  = 1'b0;
        pkt_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_dvalid) begin
                    if (data_afull || pkt_afull) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d  = ST_DATA;
                        tdata_d  = rx_data;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                        len_d    = LEN_W'(1);
                    end
                end
            end
            ST_DATA: begin
                idle_d = rx_dvalid ? '0 : idle_q + 1'b1;
                if (rx_dvalid) begin
                    if (free_slot) begin
                        tdata_d  = rx_data;
                        tvalid_d = 1'b1;
                        len_d    = len_q + 1'b1;
                    end else begin
                        ovr_d   = 1'b1;
                        ovr_inc = 1'b1;
                    end
                end
                if ((idle_d == thr) ||
                    (rx_dvalid && free_slot && (len_d == LEN_W'(MAX_PKT)))) begin
                    state_d = ST_TRAILER;
                    tbeat_d = '0;
                end
            end
            ST_TRAILER: begin
                // Late bytes are counted but never tag the packet being closed.
                ovr_inc = rx_dvalid;
                if (tvalid_q && tlast_q) begin
                    if (hs) begin
                        state_d = ST_IDLE;
                        tlast_d = 1'b0;
                        tuser_d = 1'b0;
                        push_d  = 1'b1;
                        plen_d  = tot;
                        tid_d   = tid_q + 1'b1;
                        pkt_inc = 1'b1;
                        ovr_d   = 1'b0;
                    end
                end else if (free_slot) begin
                    // A still-pending payload beat drains before the first trailer beat.
                    tdata_d  = DATA_W'(tbyte);
                    tvalid_d = 1'b1;
                    tlast_d  = (tbeat_q == 3'(LEN_BYTES - 1));
                    tuser_d  = tlast_d & ovr_q;
                    tbeat_d  = tbeat_q + 1'b1;
                end
            end
            ST_DROP: begin
                idle_d = rx_dvalid ? '0 : idle_q + 1'b1;
                if (idle_d == thr) begin
                    state_d  = ST_IDLE;
                    drop_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            tid_q    <= '0;
            tdest_q  <= '0;
            len_q    <= '0;
            plen_q   <= '0;
            push_q   <= 1'b0;
            idle_q   <= '0;
            ovr_q    <= 1'b0;
            tbeat_q  <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest;
            len_q    <= len_d;
            plen_q   <= plen_d;
            push_q   <= push_d;
            idle_q   <= idle_d;
            ovr_q    <= ovr_d;
            tbeat_q  <= tbeat_d;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tkeep    = tvalid_q;
    assign m_axis_tid      = tid_q;
    assign m_axis_tdest    = tdest_q;
    assign m_axis_tuser    = tuser_q;
    assign pkt_length      = plen_q;
    assign pkt_length_push = push_q;

`ifdef UART_STREAM_BRIDGE_STATS_EN
    logic [CNT_W-1:0] drop_q, ovrc_q, pkt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_q <= '0;
            ovrc_q <= '0;
            pkt_q  <= '0;
        end else begin
            drop_q <= sat_inc(drop_q, drop_inc);
            ovrc_q <= sat_inc(ovrc_q, ovr_inc);
            pkt_q  <= sat_inc(pkt_q, pkt_inc);
        end
    end

    assign drop_cnt = drop_q;
    assign ovr_cnt  = ovrc_q;
    assign pkt_cnt  = pkt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{drop_inc, ovr_inc, pkt_inc};
    assign drop_cnt = '0;
    assign ovr_cnt  = '0;
    assign pkt_cnt  = '0;
`endif

    uart_stream_tx #(.DATA_W(DATA_W)) u_tx (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .tx_busy       (tx_busy),
        .tx_dvalid     (tx_dvalid),
        .tx_data       (tx_data)
    );

endmodule

// File: tb/tb_uart_stream_bridge.sv
`timescale 1ns/1ps
module tb_uart_stream_bridge;

`ifdef UART_STREAM_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] cfg;
    logic [4:0]  tdest_in;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tkeep, m_tready, tx_busy;
    logic        rx_dvalid, data_afull, pkt_afull;
    logic [7:0]  rx_data;

    logic        a_sready, a_mvalid, a_mlast, a_mkeep, a_muser, a_txv, a_push;
    logic [7:0]  a_mdata, a_txd;
    logic [4:0]  a_mid, a_mdest;
    logic [31:0] a_plen;
    logic [15:0] a_drop, a_ovr, a_pkt;
    logic        b_sready, b_mvalid, b_mlast, b_mkeep, b_muser, b_txv, b_push;
    logic [7:0]  b_mdata, b_txd;
    logic [4:0]  b_mid, b_mdest;
    logic [31:0] b_plen;
    logic [15:0] b_drop, b_ovr, b_pkt;

    uart_stream_bridge #(.LEN_BYTES(4), .MAX_PKT(1024)) u_a (
        .clk(clk), .rstn(rstn), .cfg_idle_ticks(cfg), .tdest(tdest_in),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_sready),
        .s_axis_tlast(s_tlast), .s_axis_tkeep(s_tkeep),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(a_mlast), .m_axis_tkeep(a_mkeep), .m_axis_tid(a_mid),
        .m_axis_tdest(a_mdest), .m_axis_tuser(a_muser),
        .tx_busy(tx_busy), .tx_dvalid(a_txv), .tx_data(a_txd),
        .rx_dvalid(rx_dvalid), .rx_data(rx_data), .data_afull(data_afull), .pkt_afull(pkt_afull),
        .pkt_length(a_plen), .pkt_length_push(a_push),
        .drop_cnt(a_drop), .ovr_cnt(a_ovr), .pkt_cnt(a_pkt));

    uart_stream_bridge #(.LEN_BYTES(2), .MAX_PKT(4)) u_b (
        .clk(clk), .rstn(rstn), .cfg_idle_ticks(cfg), .tdest(tdest_in),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_sready),
        .s_axis_tlast(s_tlast), .s_axis_tkeep(s_tkeep),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(b_mlast), .m_axis_tkeep(b_mkeep), .m_axis_tid(b_mid),
        .m_axis_tdest(b_mdest), .m_axis_tuser(b_muser),
        .tx_busy(tx_busy), .tx_dvalid(b_txv), .tx_data(b_txd),
        .rx_dvalid(rx_dvalid), .rx_data(rx_data), .data_afull(data_afull), .pkt_afull(pkt_afull),
        .pkt_length(b_plen), .pkt_length_push(b_push),
        .drop_cnt(b_drop), .ovr_cnt(b_ovr), .pkt_cnt(b_pkt));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected beats and lengths per DUT (0 = 4-byte trailer,
    // 1 = 2-byte trailer with 4-byte max payload).
    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       user;
        logic [4:0] id;
    } beat_t;

    beat_t       qa[$], qb[$];
    logic [31:0] la[$], lb[$];
    logic [7:0]  pb[$];
    int          tidm[2], pktm[2];
    int          dropm, ovrm;

    task automatic model_pkt(input bit ovr);
        int lbs, mp, n, i, k, tot;
        beat_t x;
        for (int d = 0; d < 2; d++) begin
            lbs = (d == 0) ? 4 : 2;
            mp  = (d == 0) ? 1024 : 4;
            n   = pb.size();
            i   = 0;
            while (i < n) begin
                k = (n - i > mp) ? mp : n - i;
                for (int j = 0; j < k; j++) begin
                    x = '{d: pb[i+j], last: 1'b0, user: 1'b0, id: 5'(tidm[d])};
                    if (d == 0) qa.push_back(x); else qb.push_back(x);
                end
                i   = i + k;
                tot = k + lbs;
                for (int t = 0; t < lbs; t++) begin
                    x.d    = 8'((tot >> (8 * (lbs - 1 - t))) & 255);
                    x.last = (t == lbs - 1);
                    x.user = x.last & ovr & (i == n);
                    x.id   = 5'(tidm[d]);
                    if (d == 0) qa.push_back(x); else qb.push_back(x);
                end
                if (d == 0) la.push_back(32'(tot)); else lb.push_back(32'(tot));
                tidm[d] = (tidm[d] + 1) % 32;
                pktm[d]++;
            end
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rstn) begin
            if (a_mvalid && m_tready) begin
                if (qa.size() == 0) check("a_unexpected_beat", a_mvalid, 1'b0);
                else begin
                    e = qa.pop_front();
                    check("a_beat", {a_mdata, a_mlast, a_muser, a_mid, a_mkeep},
                          {e.d, e.last, e.user, e.id, 1'b1});
                end
            end
            if (a_push) begin
                if (la.size() == 0) check("a_unexpected_push", a_push, 1'b0);
                else check("a_pkt_length", a_plen, la.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rstn) begin
            if (b_mvalid && m_tready) begin
                if (qb.size() == 0) check("b_unexpected_beat", b_mvalid, 1'b0);
                else begin
                    e = qb.pop_front();
                    check("b_beat", {b_mdata, b_mlast, b_muser, b_mid, b_mkeep},
                          {e.d, e.last, e.user, e.id, 1'b1});
                end
            end
            if (b_push) begin
                if (lb.size() == 0) check("b_unexpected_push", b_push, 1'b0);
                else check("b_pkt_length", b_plen, lb.pop_front());
            end
        end
    end

    int         cyc_n = 0;
    logic [7:0] txd[$];
    int         txt[$];
    always @(posedge clk) cyc_n++;
    always @(negedge clk) if (rstn && a_txv) begin
        txd.push_back(a_txd);
        txt.push_back(cyc_n);
    end

    // All stimulus tasks assume they are entered 1ns after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_dvalid = 1'b1;
        rx_data   = b;
        cyc(1);
        rx_dvalid = 1'b0;
        cyc(gap - 1);
    endtask

    task automatic send_pb(input int gap);
        foreach (pb[i]) send_byte(pb[i], gap);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_a_axis"}, {a_mvalid, a_mdata, a_mlast, a_mkeep, a_muser, a_mid, a_mdest}, '0);
        check({tag, "_a_misc"}, {a_plen, a_push, a_txv, a_txd, a_sready, a_drop, a_ovr, a_pkt}, '0);
        check({tag, "_b_axis"}, {b_mvalid, b_mdata, b_mlast, b_mkeep, b_muser, b_mid, b_mdest}, '0);
        check({tag, "_b_misc"}, {b_plen, b_push, b_txv, b_txd, b_sready, b_drop, b_ovr, b_pkt}, '0);
    endtask

    task automatic chk_cnt(input string tag);
        check({tag, "_a_cnt"}, {a_drop, a_ovr, a_pkt},
              STATS ? {16'(dropm), 16'(ovrm), 16'(pktm[0])} : 48'd0);
        check({tag, "_b_cnt"}, {b_drop, b_ovr, b_pkt},
              STATS ? {16'(dropm), 16'(ovrm), 16'(pktm[1])} : 48'd0);
    endtask

    initial begin
        int n, gap, w;
        cfg = 16'd10; tdest_in = 5'h13;
        s_tdata = '0; s_tvalid = 0; s_tlast = 0; s_tkeep = 0;
        m_tready = 1; tx_busy = 0;
        rx_dvalid = 0; rx_data = '0; data_afull = 0; pkt_afull = 0;
        tidm = '{0, 0}; pktm = '{0, 0}; dropm = 0; ovrm = 0;

        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rstn = 1'b1;
        cyc(3);
        check("tdest_reg", a_mdest, 5'h13);

        // Basic packet, then a second one that must carry tid 1
        pb = '{8'h11, 8'h22, 8'h33};
        model_pkt(0); send_pb(4); cyc(30);
        pb = '{8'hC4, 8'h3B};
        model_pkt(0); send_pb(4); cyc(30);

        // Six bytes: max-length split on the short-trailer instance
        pb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        model_pkt(0); send_pb(4); cyc(30);
        chk_cnt("after_split");

        // Almost-full at the first byte drops the whole burst
        pkt_afull = 1'b1; rx_dvalid = 1'b1; rx_data = 8'hEE;
        cyc(1);
        pkt_afull = 1'b0; rx_dvalid = 1'b0;
        cyc(3);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h50), 4);
        cyc(30);
        dropm++;
        chk_cnt("after_drop");
        pb = '{8'h9A, 8'h9B};
        model_pkt(0); send_pb(4); cyc(30);

        // Overrun: two bytes arrive while the output register is stalled
        m_tready = 1'b0;
        send_byte(8'hA1, 1);
        send_byte(8'hA2, 1);
        send_byte(8'hA3, 1);
        m_tready = 1'b1;
        pb = '{8'hA1};
        model_pkt(1);
        ovrm += 2;
        cyc(30);
        chk_cnt("after_ovr");
        pb = '{8'h5C};
        model_pkt(0); send_pb(4); cyc(30);

        // Timeout 0 acts as 1: each byte is its own packet
        cfg = 16'd0;
        pb = '{8'h71}; model_pkt(0); send_byte(8'h71, 8);
        pb = '{8'h72}; model_pkt(0); send_byte(8'h72, 8);
        cyc(20);
        cfg = 16'd10;

        // Nine idle cycles between bytes stay inside one packet
        pb = '{8'h81, 8'h82};
        model_pkt(0); send_pb(10); cyc(30);

        // Randomised packets
        for (int p = 0; p < 30; p++) begin
            n   = $urandom_range(1, 9);
            gap = $urandom_range(4, 7);
            pb.delete();
            for (int i = 0; i < n; i++) pb.push_back(8'($urandom));
            model_pkt(0); send_pb(gap); cyc(30);
        end
        check("a_queue_drained", {32'(qa.size()), 32'(la.size())}, 64'd0);
        check("b_queue_drained", {32'(qb.size()), 32'(lb.size())}, 64'd0);
        chk_cnt("after_random");

        // TX path
        s_tvalid = 1'b1; s_tdata = 8'hA5;
        w = 0;
        while (!a_sready && w < 20) begin cyc(1); w++; end
        check("tx_hs1_ready", a_sready, 1'b1);
        cyc(1);
        s_tdata = 8'h5A;
        w = 0;
        while (!a_sready && w < 20) begin cyc(1); w++; end
        check("tx_hs2_ready", a_sready, 1'b1);
        cyc(1);
        s_tvalid = 1'b0;
        cyc(5);
        check("tx_count", txd.size(), 2);
        if (txd.size() == 2) begin
            check("tx_data", {txd[0], txd[1]}, 16'hA55A);
            check("tx_spacing", (txt[1] - txt[0]) >= 2, 1'b1);
        end
        tx_busy = 1'b1;
        cyc(2);
        s_tvalid = 1'b1; s_tdata = 8'hC3;
        cyc(3);
        check("tx_busy_ready", {a_sready, 32'(txd.size())}, {1'b0, 32'd2});
        s_tvalid = 1'b0;
        tx_busy = 1'b0;
        cyc(3);

        // Reset while a packet is closing
        m_tready = 1'b0;
        send_byte(8'h77, 1);
        cyc(15);
        check("held_payload", {a_mvalid, a_mdata, a_mlast}, {1'b1, 8'h77, 1'b0});
        #3 rstn = 1'b0;
        #1 chk_zero("async_reset");
        qa.delete(); qb.delete(); la.delete(); lb.delete();
        tidm = '{0, 0}; pktm = '{0, 0}; dropm = 0; ovrm = 0;
        cyc(2);
        rstn = 1'b1;
        m_tready = 1'b1;
        cyc(2);
        pb = '{8'h3D, 8'h4E};
        model_pkt(0); send_pb(4); cyc(40);
        check("a_post_reset_drained", {32'(qa.size()), 32'(la.size())}, 64'd0);
        check("b_post_reset_drained", {32'(qb.size()), 32'(lb.size())}, 64'd0);
        chk_cnt("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
